cop0_exception_dispatch: RTL

// Pipeline-side counterpart of the COP0 register file: collects synchronous exception flags from the

---
 rtl/cop0_exception_dispatch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cop0_exception_dispatch.sv
// Exception dispatch for the COP0 pipeline: prioritises synchronous faults and interrupts,
// hands code/BD/EPC to COP0 and sequences the stall, flush and PC redirect into the handler.
module cop0_exception_dispatch #(
    parameter logic [31:0] EXC_VECTOR   = 32'h80000180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        iCLK,
    input  logic        iCLR,
    input  logic [7:0]  iInterruptMask,
    input  logic        iExcLevel,
    input  logic        iEret,
    input  logic [31:0] iPC,
    input  logic        iInBranchDelay,
    input  logic        iAdEL,
    input  logic        iAdES,
    input  logic        iRI,
    input  logic        iOv,
    input  logic        iSys,
    input  logic        iBp,
    output logic        oExcOccurred,
    output logic [4:0]  oExcCode,
    output logic        oBranchDelay,
    output logic [31:0] oEPC,
    output logic        oStallReq,
    output logic        oFlush,
    output logic        oPCSrcExc,
    output logic [31:0] oExcVector,
    output logic        oDoubleFault
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMMIT  = 2'd1,
        S_FLUSH   = 2'd2,
        S_WAIT_EL = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [2:0]  r_flushCnt;
    logic [4:0]  r_code;
    logic        r_bd;
    logic [31:0] r_epc;
    logic        r_doubleFault;

    logic        w_anySync;
    logic        w_intReq;
    logic        w_dispatch;
    logic        w_lastFlush;
    logic [4:0]  w_code;
    logic [31:0] w_epc;

    assign w_anySync   = iAdEL | iAdES | iRI | iOv | iSys | iBp;
    assign w_intReq    = (|iInterruptMask) & ~iEret;
    assign w_dispatch  = ~iExcLevel & (w_anySync | w_intReq);
    assign w_lastFlush = (r_flushCnt == FLUSH_LAST);

    // eret resumes at EPC when BD is set and at EPC+4 otherwise, so only a
    // non-delay-slot synchronous fault records the faulting PC itself.
    assign w_epc = (iInBranchDelay | ~w_anySync) ? (iPC - 32'd4) : iPC;

    always_comb begin
        w_code = 5'd0;
        if (iAdEL)      w_code = 5'd4;
        else if (iAdES) w_code = 5'd5;
        else if (iRI)   w_code = 5'd10;
        else if (iOv)   w_code = 5'd12;
        else if (iSys)  w_code = 5'd8;
        else if (iBp)   w_code = 5'd9;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (w_dispatch) w_nextState = S_COMMIT;
            S_COMMIT:  w_nextState = S_FLUSH;
            S_FLUSH:   if (w_lastFlush) w_nextState = iExcLevel ? S_IDLE : S_WAIT_EL;
            S_WAIT_EL: if (iExcLevel) w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iCLR) begin
        if (!iCLR) begin
            r_state       <= S_IDLE;
            r_flushCnt    <= 3'd0;
            r_code        <= 5'd0;
            r_bd          <= 1'b0;
            r_epc         <= 32'd0;
            r_doubleFault <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_FLUSH && !w_lastFlush)
                r_flushCnt <= r_flushCnt + 3'd1;
            else
                r_flushCnt <= 3'd0;
            if (r_state == S_IDLE && w_dispatch) begin
                r_code <= w_code;
                r_bd   <= iInBranchDelay;
                r_epc  <= w_epc;
            end
            // A fault while already in the handler cannot be reported; latch it for software.
            if (r_state == S_IDLE && w_anySync && iExcLevel)
                r_doubleFault <= 1'b1;
        end
    end

    assign oExcOccurred = (r_state == S_COMMIT);
    assign oStallReq    = (r_state == S_COMMIT);
    assign oFlush       = (r_state == S_FLUSH);
    assign oPCSrcExc    = (r_state == S_FLUSH) && (r_flushCnt == 3'd0);
    assign oExcCode     = r_code;
    assign oBranchDelay = r_bd;
    assign oEPC         = r_epc;
    assign oDoubleFault = r_doubleFault;
    assign oExcVector   = EXC_VECTOR;

endmodule
